// File: rtl/icache_refill_unit.sv
// Purpose: ICache miss handler; one burst read per miss, beats assembled into a line, single-cycle refill strobe.
// Latency: request valid 1 cycle after miss handshake; refill strobe 1 cycle after the final beat (BEATS+2 with zero-wait memory).
// Backpressure: holds mem request until ready, accepts beats whenever valid in RECV/DRAIN, takes one miss at a time.
module icache_refill_unit #(
    parameter int PLEN       = 32,
    parameter int LINE_WIDTH = 512,
    parameter int BUS_WIDTH  = 64,
    parameter int SET_ASSOC  = 4,
    parameter int NUM_SETS   = 64,
    localparam int WAY_W     = (SET_ASSOC > 1) ? $clog2(SET_ASSOC) : 1,
    localparam int IDX_W     = $clog2(NUM_SETS),
    localparam int OFF_W     = $clog2(LINE_WIDTH / 8),
    localparam int TAG_W     = PLEN - IDX_W - OFF_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  miss_valid_i,
    output logic                  miss_ready_o,
    input  logic [PLEN-1:0]       miss_paddr_i,
    input  logic [WAY_W-1:0]      miss_way_i,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [PLEN-1:0]       mem_req_addr_o,
    output logic [7:0]            mem_req_len_o,
    input  logic                  mem_rsp_valid_i,
    output logic                  mem_rsp_ready_o,
    input  logic [BUS_WIDTH-1:0]  mem_rsp_data_i,
    input  logic                  mem_rsp_last_i,
    input  logic                  mem_rsp_err_i,
    output logic                  refill_valid_o,
    output logic [IDX_W-1:0]      refill_index_o,
    output logic [WAY_W-1:0]      refill_way_o,
    output logic [TAG_W-1:0]      refill_tag_o,
    output logic [LINE_WIDTH-1:0] refill_line_o,
    output logic                  refill_err_o,
    output logic                  busy_o
);

    localparam int BEATS = LINE_WIDTH / BUS_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, REQ, RECV, WRITE, DRAIN} state_t;

    state_t                 state;
    logic [PLEN-OFF_W-1:0]  line_addr;
    logic [WAY_W-1:0]       way_q;
    logic [CNT_W-1:0]       beat_cnt;
    logic                   err;
    logic                   flush_pend;
    logic [LINE_WIDTH-1:0]  line_q;

    logic miss_hs;
    logic req_hs;
    logic rsp_hs;
    logic at_end;
    logic final_beat;
    logic unused_off;

    // Byte offset within the line is irrelevant: refills are always whole lines.
    assign unused_off = ^miss_paddr_i[OFF_W-1:0];

    assign miss_hs    = miss_valid_i && miss_ready_o;
    assign req_hs     = mem_req_valid_o && mem_req_ready_i;
    assign rsp_hs     = mem_rsp_valid_i && mem_rsp_ready_o;
    assign at_end     = (beat_cnt == LAST_CNT);
    // Burst ends on whichever comes first: the last flag or the line filling up.
    assign final_beat = mem_rsp_last_i || at_end;

    assign miss_ready_o    = (state == IDLE) && !flush_i;
    assign mem_req_valid_o = (state == REQ);
    assign mem_req_addr_o  = {line_addr, {OFF_W{1'b0}}};
    assign mem_req_len_o   = 8'(BEATS - 1);
    assign mem_rsp_ready_o = (state == RECV) || (state == DRAIN);
    // A flush landing on the write cycle cancels the array update.
    assign refill_valid_o  = (state == WRITE) && !flush_i;
    assign refill_index_o  = line_addr[IDX_W-1:0];
    assign refill_tag_o    = line_addr[PLEN-OFF_W-1:IDX_W];
    assign refill_way_o    = way_q;
    assign refill_line_o   = line_q;
    assign refill_err_o    = err;
    assign busy_o          = (state != IDLE);

    // Refill sequencer: latch miss, issue burst, collect or drain beats, strobe the write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            line_addr  <= '0;
            way_q      <= '0;
            beat_cnt   <= '0;
            err        <= 1'b0;
            flush_pend <= 1'b0;
            line_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_hs) begin
                        line_addr  <= miss_paddr_i[PLEN-1:OFF_W];
                        way_q      <= miss_way_i;
                        flush_pend <= 1'b0;
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // The request cannot be withdrawn, so a flush here only marks the burst for draining.
                    if (req_hs) begin
                        beat_cnt   <= '0;
                        err        <= 1'b0;
                        flush_pend <= 1'b0;
                        state      <= (flush_pend || flush_i) ? DRAIN : RECV;
                    end else if (flush_i) begin
                        flush_pend <= 1'b1;
                    end
                end
                RECV: begin
                    if (rsp_hs) begin
                        line_q[beat_cnt*BUS_WIDTH +: BUS_WIDTH] <= mem_rsp_data_i;
                        // Poison on a bus error, or when last and line-full disagree.
                        err      <= err | mem_rsp_err_i | (mem_rsp_last_i ^ at_end);
                        beat_cnt <= at_end ? '0 : beat_cnt + 1'b1;
                        if (flush_i) begin
                            state <= final_beat ? IDLE : DRAIN;
                        end else if (final_beat) begin
                            state <= WRITE;
                        end
                    end else if (flush_i) begin
                        state <= DRAIN;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (rsp_hs) begin
                        beat_cnt <= at_end ? '0 : beat_cnt + 1'b1;
                        if (final_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Purpose: randomized and directed bench for icache_refill_unit against a transaction-level line model.
// Latency: checks request, per-beat acceptance, refill cycle and return to idle relative to the final beat.
// Backpressure: varies request-ready delay and beat gaps; flushes injected in IDLE, REQ, RECV and WRITE.
module tb_icache_refill_unit;

    localparam int PLEN       = 32;
    localparam int LINE_WIDTH = 512;
    localparam int BUS_WIDTH  = 64;
    localparam int SET_ASSOC  = 4;
    localparam int NUM_SETS   = 64;
    localparam int WAY_W      = 2;
    localparam int IDX_W      = 6;
    localparam int TAG_W      = 20;
    localparam int BEATS      = LINE_WIDTH / BUS_WIDTH;
    localparam int LINE_BYTES = LINE_WIDTH / 8;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic                  flush_i;
    logic                  miss_valid_i;
    logic                  miss_ready_o;
    logic [PLEN-1:0]       miss_paddr_i;
    logic [WAY_W-1:0]      miss_way_i;
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    logic [PLEN-1:0]       mem_req_addr_o;
    logic [7:0]            mem_req_len_o;
    logic                  mem_rsp_valid_i;
    logic                  mem_rsp_ready_o;
    logic [BUS_WIDTH-1:0]  mem_rsp_data_i;
    logic                  mem_rsp_last_i;
    logic                  mem_rsp_err_i;
    logic                  refill_valid_o;
    logic [IDX_W-1:0]      refill_index_o;
    logic [WAY_W-1:0]      refill_way_o;
    logic [TAG_W-1:0]      refill_tag_o;
    logic [LINE_WIDTH-1:0] refill_line_o;
    logic                  refill_err_o;
    logic                  busy_o;

    always #5 clk = ~clk;

    icache_refill_unit #(
        .PLEN(PLEN), .LINE_WIDTH(LINE_WIDTH), .BUS_WIDTH(BUS_WIDTH),
        .SET_ASSOC(SET_ASSOC), .NUM_SETS(NUM_SETS)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .miss_valid_i(miss_valid_i), .miss_ready_o(miss_ready_o),
        .miss_paddr_i(miss_paddr_i), .miss_way_i(miss_way_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_len_o(mem_req_len_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_last_i(mem_rsp_last_i),
        .mem_rsp_err_i(mem_rsp_err_i),
        .refill_valid_o(refill_valid_o), .refill_index_o(refill_index_o),
        .refill_way_o(refill_way_o), .refill_tag_o(refill_tag_o),
        .refill_line_o(refill_line_o), .refill_err_o(refill_err_o),
        .busy_o(busy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Per-cycle observations taken in step()
    bit                    hs_miss, hs_req, hs_rsp;
    bit                    obs_busy, obs_req_vld, obs_rsp_rdy;
    logic [PLEN-1:0]       obs_req_addr;
    int                    n_refill;
    int                    ref_cyc;
    logic [IDX_W-1:0]      cap_idx;
    logic [WAY_W-1:0]      cap_way;
    logic [TAG_W-1:0]      cap_tag;
    logic [LINE_WIDTH-1:0] cap_line;
    logic                  cap_err;
    int                    last_c0;
    logic [PLEN-1:0]       last_req_addr;
    logic [LINE_WIDTH-1:0] line1;

    task automatic chk_eq(input string tag, input logic [LINE_WIDTH-1:0] got,
                          input logic [LINE_WIDTH-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are set at the falling edge; outputs sampled 1ns later; then advance one cycle.
    task automatic step();
        #1;
        hs_miss      = miss_valid_i && miss_ready_o;
        hs_req       = mem_req_valid_o && mem_req_ready_i;
        hs_rsp       = mem_rsp_valid_i && mem_rsp_ready_o;
        obs_busy     = busy_o;
        obs_req_vld  = mem_req_valid_o;
        obs_req_addr = mem_req_addr_o;
        obs_rsp_rdy  = mem_rsp_ready_o;
        if (refill_valid_o) begin
            n_refill++;
            ref_cyc  = cyc;
            cap_idx  = refill_index_o;
            cap_way  = refill_way_o;
            cap_tag  = refill_tag_o;
            cap_line = refill_line_o;
            cap_err  = refill_err_o;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush_i         = 1'b0;
        miss_valid_i    = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_last_i  = 1'b0;
        mem_rsp_err_i   = 1'b0;
        mem_rsp_data_i  = {$urandom, $urandom};
    endtask

    task automatic chk_reset(input string tag);
        chk_eq({tag, "_miss_rdy"}, miss_ready_o, 1);
        chk_eq({tag, "_req_vld"}, mem_req_valid_o, 0);
        chk_eq({tag, "_req_addr"}, mem_req_addr_o, 0);
        chk_eq({tag, "_req_len"}, mem_req_len_o, BEATS - 1);
        chk_eq({tag, "_rsp_rdy"}, mem_rsp_ready_o, 0);
        chk_eq({tag, "_ref_vld"}, refill_valid_o, 0);
        chk_eq({tag, "_ref_idx"}, refill_index_o, 0);
        chk_eq({tag, "_ref_tag"}, refill_tag_o, 0);
        chk_eq({tag, "_ref_way"}, refill_way_o, 0);
        chk_eq({tag, "_ref_line"}, refill_line_o, 0);
        chk_eq({tag, "_ref_err"}, refill_err_o, 0);
        chk_eq({tag, "_busy"}, busy_o, 0);
    endtask

    // One miss with a scripted memory. fmode: 0 none, 1 flush in REQ, 2 flush with beat fk, 3 flush in WRITE.
    // last_at >= BEATS means the burst never flags last.
    task automatic run_txn(input logic [PLEN-1:0] paddr, input int way, input int req_wait,
                           input int gap, input int err_beat, input int last_at,
                           input int fmode, input int fk_in, input bit fixed);
        logic [BUS_WIDTH-1:0]  dat [BEATS];
        logic [LINE_WIDTH-1:0] exp_line, mask;
        logic [PLEN-1:0]       exp_addr;
        int  mem_beats, sent, gap_ctr, wait_ctr, last_hs, idle_cyc, guard, fk;
        bit  req_acc, fl_next, idle_seen, drained, flushed, exp_err;

        mem_beats = (last_at < BEATS) ? last_at + 1 : BEATS;
        fk        = (fk_in < mem_beats) ? fk_in : mem_beats - 1;
        drained   = (fmode == 1) || (fmode == 2);
        flushed   = (fmode != 0);
        exp_addr  = paddr - (paddr % LINE_BYTES);
        exp_err   = ((err_beat >= 0) && (err_beat < mem_beats)) || (last_at != BEATS - 1);
        for (int i = 0; i < BEATS; i++)
            dat[i] = fixed ? (64'h1111_0000_0000_0000 | 64'(i)) : {$urandom, $urandom};

        idle_inputs();
        miss_valid_i = 1'b1;
        miss_paddr_i = paddr;
        miss_way_i   = WAY_W'(way);
        n_refill     = 0;
        step();
        chk_eq("miss_hs", hs_miss, 1);
        last_c0      = cyc - 1;
        miss_valid_i = 1'b0;
        miss_paddr_i = $urandom;
        miss_way_i   = WAY_W'($urandom);

        sent = 0; gap_ctr = 0; wait_ctr = 0; last_hs = 0; idle_cyc = 0; guard = 0;
        req_acc = 0; fl_next = 0; idle_seen = 0;
        while (!idle_seen && guard < 400) begin
            idle_inputs();
            if (fl_next) begin
                flush_i = 1'b1;
                fl_next = 0;
            end
            if (!req_acc) begin
                mem_req_ready_i = (wait_ctr >= req_wait);
                if (fmode == 1 && wait_ctr == 0) flush_i = 1'b1;
                wait_ctr++;
            end else if (sent < mem_beats && gap_ctr == 0) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = dat[sent];
                mem_rsp_last_i  = (sent == last_at);
                mem_rsp_err_i   = (sent == err_beat);
                if (fmode == 2 && sent == fk) flush_i = 1'b1;
            end
            step();
            if (!req_acc) begin
                chk_eq("req_vld", obs_req_vld, 1);
                chk_eq("req_addr", obs_req_addr, exp_addr);
            end
            if (mem_rsp_valid_i) chk_eq("rsp_rdy", obs_rsp_rdy, 1);
            if (hs_req) begin
                req_acc = 1;
                last_req_addr = obs_req_addr;
            end
            if (hs_rsp) begin
                sent++;
                gap_ctr = gap;
                if (sent == mem_beats) begin
                    last_hs = cyc - 1;
                    if (fmode == 3) fl_next = 1;
                end
            end else if (gap_ctr > 0) begin
                gap_ctr--;
            end
            if (sent == mem_beats && !obs_busy) begin
                idle_seen = 1;
                idle_cyc  = cyc - 1;
            end
            guard++;
        end
        idle_inputs();

        chk_eq("in_budget", idle_seen, 1);
        chk_eq("idle_delay", idle_cyc - last_hs, drained ? 1 : 2);
        chk_eq("n_refill", n_refill, flushed ? 0 : 1);
        if (!flushed && n_refill == 1) begin
            exp_line = '0;
            mask     = '0;
            for (int i = 0; i < mem_beats; i++) begin
                exp_line[i*BUS_WIDTH +: BUS_WIDTH] = dat[i];
                mask[i*BUS_WIDTH +: BUS_WIDTH]     = '1;
            end
            chk_eq("refill_delay", ref_cyc - last_hs, 1);
            chk_eq("refill_idx", cap_idx, (paddr / LINE_BYTES) % NUM_SETS);
            chk_eq("refill_tag", cap_tag, paddr / (LINE_BYTES * NUM_SETS));
            chk_eq("refill_way", cap_way, way);
            chk_eq("refill_err", cap_err, exp_err);
            chk_eq("refill_line", cap_line & mask, exp_line);
        end
    endtask

    initial begin
        int fm, la, eb;

        idle_inputs();
        miss_paddr_i = '0;
        miss_way_i   = '0;
        rst_i        = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset("por");
        rst_i = 1'b0;

        // Defaults: zero-wait memory, known data
        run_txn(32'h8000_1234, 2, 0, 0, -1, BEATS - 1, 0, 0, 1);
        chk_eq("t1_latency", ref_cyc - last_c0, BEATS + 2);
        chk_eq("t1_addr", last_req_addr, 32'h8000_1200);
        chk_eq("t1_len", mem_req_len_o, 7);
        chk_eq("t1_idx", cap_idx, 8'h08);
        chk_eq("t1_tag", cap_tag, 20'h80001);
        chk_eq("t1_way", cap_way, 2);
        chk_eq("t1_err", cap_err, 0);
        chk_eq("t1_beat0", cap_line[63:0], 64'h1111_0000_0000_0000);
        line1 = cap_line;

        // Backpressure on request and gaps between beats
        run_txn(32'h8000_1234, 2, 3, 2, -1, BEATS - 1, 0, 0, 1);
        chk_eq("bp_line", cap_line, line1);

        // Bus error on beat 5
        run_txn(32'h8000_1234, 2, 0, 0, 5, BEATS - 1, 0, 0, 1);
        chk_eq("err_flag", cap_err, 1);

        // Early last on beat 3
        run_txn(32'h0001_2340, 1, 0, 1, -1, 3, 0, 0, 0);
        chk_eq("early_err", cap_err, 1);

        // Flush in IDLE blocks a new miss
        idle_inputs();
        flush_i      = 1'b1;
        miss_valid_i = 1'b1;
        step();
        chk_eq("flush_blocks_miss", hs_miss, 0);
        idle_inputs();
        #1;
        chk_eq("flush_idle_busy", busy_o, 0);

        // Flush during RECV with beat 2, then a fresh miss
        run_txn(32'h8000_1234, 3, 0, 0, -1, BEATS - 1, 2, 2, 0);
        run_txn(32'h8000_1234, 2, 0, 0, -1, BEATS - 1, 0, 0, 1);
        chk_eq("after_flush_line", cap_line, line1);

        // Flush in REQ while memory not ready
        run_txn(32'hdead_beef, 0, 3, 0, -1, BEATS - 1, 1, 0, 0);
        // Flush on the write cycle
        run_txn(32'h1234_5678, 3, 1, 0, -1, BEATS - 1, 3, 0, 0);

        // Reset in the middle of RECV
        idle_inputs();
        miss_valid_i = 1'b1;
        miss_paddr_i = 32'hcafe_f00d;
        miss_way_i   = 2'd3;
        step();
        idle_inputs();
        mem_req_ready_i = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            mem_rsp_valid_i = 1'b1;
            step();
        end
        idle_inputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        chk_reset("mid_rst");

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            fm = $urandom_range(0, 9);
            la = $urandom_range(0, 5);
            eb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, BEATS - 1)) : -1;
            run_txn($urandom, $urandom_range(0, SET_ASSOC - 1), $urandom_range(0, 3),
                    $urandom_range(0, 2), eb,
                    (la == 0) ? int'($urandom_range(0, BEATS - 2)) : (la == 1) ? 99 : BEATS - 1,
                    (fm < 6) ? 0 : (fm == 9) ? 3 : fm - 5,
                    $urandom_range(0, BEATS - 1), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
